// File: rtl/sort_result_serializer.sv
// sort_result_serializer: captures a finished sort frame on the rising edge of
// the sorter's done flag and streams its elements out over valid/ready, index 0
// first. The sorter may start the next sort while this frame drains.
// Optional macro SORT_CHECK_EN: flags an out-of-order (descending) element
// within a frame on o_order_err; without it o_order_err is tied to 0.
module sort_result_serializer #(
  parameter  int SIZE_DATA = 8,
  parameter  int NUM_VALS  = 8,
  localparam int IDX_W     = $clog2(NUM_VALS)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_done,
  input  logic [NUM_VALS*SIZE_DATA-1:0] i_data,
  output logic                          o_busy,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [SIZE_DATA-1:0]          o_data,
  output logic [IDX_W-1:0]              o_index,
  output logic                          o_last,
  output logic                          o_frame_done,
  output logic                          o_overrun,
  output logic                          o_order_err
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state;
  state_t               state_next;
  logic                 done_q;
  logic                 edge_det;
  logic                 acc;
  logic                 finish;
  logic                 capture;
  logic [SIZE_DATA-1:0] cap_q [NUM_VALS];

  assign edge_det = i_done & ~done_q;
  assign o_valid  = (state == STREAM);
  assign o_busy   = (state == STREAM);
  assign acc      = o_valid & i_ready;
  assign o_last   = (o_index == IDX_W'(NUM_VALS - 1)) & o_valid;
  assign finish   = acc & o_last;
  // A new frame is taken when idle, or when the last element leaves this cycle.
  assign capture  = edge_det & ((state == IDLE) | finish);
  assign o_data   = cap_q[o_index];

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: enter STREAM on a done edge, leave it after the last element
  // unless a back-to-back frame is captured on that same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (edge_det) state_next = STREAM;
      STREAM:  if (finish && !edge_det) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame capture, element index, done-edge history and status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      done_q       <= 1'b0;
      o_index      <= '0;
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
      for (int k = 0; k < NUM_VALS; k++) cap_q[k] <= '0;
    end else begin
      done_q       <= i_done;
      o_frame_done <= finish;
      if (capture) begin
        for (int k = 0; k < NUM_VALS; k++) cap_q[k] <= i_data[k*SIZE_DATA +: SIZE_DATA];
        o_index <= '0;
      end else if (finish) begin
        o_index <= '0;
      end else if (acc) begin
        o_index <= o_index + 1'b1;
      end
      if (edge_det && !capture) o_overrun <= 1'b1;
    end
  end

`ifdef SORT_CHECK_EN
  logic [SIZE_DATA-1:0] prev_q;

  // Remember each accepted element and flag a descent within the frame; a new
  // capture starts the frame with a clean flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q      <= '0;
      o_order_err <= 1'b0;
    end else begin
      if (acc) prev_q <= o_data;
      if (capture)
        o_order_err <= 1'b0;
      else if (acc && (o_index != '0) && (o_data < prev_q))
        o_order_err <= 1'b1;
    end
  end
`else
  assign o_order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_result_serializer.sv
// tb_sort_result_serializer: vector table, hand-written corner sequences and a
// randomized run, all compared against a queue-based reference model.
module tb_sort_result_serializer;

  localparam int NV = 4;
  localparam int SD = 8;
`ifdef SORT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_done = 1'b0;
  logic [NV*SD-1:0] i_data = '0;
  logic          i_ready = 1'b0;
  logic          o_busy, o_valid, o_last, o_frame_done, o_overrun, o_order_err;
  logic [SD-1:0] o_data;
  logic [1:0]    o_index;

  int checks = 0;
  int errors = 0;

  // Reference model: the remaining elements of the frame in flight, in order.
  logic [SD-1:0] mq[$];
  logic [SD-1:0] m_prev = '0;
  bit            m_done_q = 1'b0;
  bit            m_fd = 1'b0;
  bit            m_ovr = 1'b0;
  bit            m_err = 1'b0;

  typedef struct {
    logic        rst;
    logic        done;
    logic [31:0] data;
    logic        ready;
    logic        ev;
    logic [1:0]  eidx;
    logic [7:0]  edata;
    logic        elast;
    logic        efd;
    logic        eov;
  } vec_t;

  vec_t vq[$];

  // Free-running clock.
  always #5 clk = ~clk;

  sort_result_serializer #(.SIZE_DATA(SD), .NUM_VALS(NV)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_done(i_done), .i_data(i_data),
    .o_busy(o_busy), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_index(o_index), .o_last(o_last), .o_frame_done(o_frame_done),
    .o_overrun(o_overrun), .o_order_err(o_order_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep(input logic rst, input logic done, input logic [31:0] data, input logic ready);
    bit edge_seen, acc, set_err;
    int idx;
    logic [SD-1:0] v;
    if (rst) begin
      mq.delete();
      m_done_q = 0; m_fd = 0; m_ovr = 0; m_err = 0; m_prev = '0;
      return;
    end
    edge_seen = done && !m_done_q;
    m_done_q  = done;
    acc       = (mq.size() > 0) && ready;
    m_fd      = 0;
    set_err   = 0;
    if (acc) begin
      idx = NV - mq.size();
      v = mq.pop_front();
      if (CHECK_EN && idx > 0 && v < m_prev) set_err = 1;
      m_prev = v;
      if (mq.size() == 0) m_fd = 1;
    end
    if (edge_seen) begin
      if (mq.size() == 0) begin
        for (int k = 0; k < NV; k++) mq.push_back(data[k*SD +: SD]);
        m_err = 0;
        set_err = 0;
      end else begin
        m_ovr = 1;
      end
    end
    if (set_err) m_err = 1;
  endtask

  task automatic checkModel();
    bit v;
    v = (mq.size() > 0);
    checkOutput("model_valid", 32'(o_valid), 32'(v));
    checkOutput("model_busy", 32'(o_busy), 32'(v));
    checkOutput("model_index", 32'(o_index), v ? 32'(NV - mq.size()) : 32'd0);
    checkOutput("model_last", 32'(o_last), 32'(v && mq.size() == 1));
    checkOutput("model_frame_done", 32'(o_frame_done), 32'(m_fd));
    checkOutput("model_overrun", 32'(o_overrun), 32'(m_ovr));
    checkOutput("model_order_err", 32'(o_order_err), 32'(m_err));
    if (v) checkOutput("model_data", 32'(o_data), 32'(mq[0]));
  endtask

  // One clock: drive on the falling edge, step the model at the rising edge,
  // compare shortly after it.
  task automatic applyStimulus(input logic rst, input logic done, input logic [31:0] data, input logic ready);
    @(negedge clk);
    i_rst = rst; i_done = done; i_data = data; i_ready = ready;
    @(posedge clk);
    modelStep(rst, done, data, ready);
    #1;
    checkModel();
  endtask

  task automatic addVec(input logic rst, input logic done, input logic [31:0] data, input logic ready,
                        input logic ev, input logic [1:0] eidx, input logic [7:0] edata,
                        input logic elast, input logic efd, input logic eov);
    vec_t t;
    t.rst = rst; t.done = done; t.data = data; t.ready = ready;
    t.ev = ev; t.eidx = eidx; t.edata = edata; t.elast = elast; t.efd = efd; t.eov = eov;
    vq.push_back(t);
  endtask

  localparam logic [31:0] FA = 32'hFF090501;
  localparam logic [31:0] FB = 32'h40302010;
  localparam logic [31:0] FX = 32'hAAAAAAAA;
  localparam logic [31:0] FO = 32'h09020703;

  initial begin
    // rst done data ready | valid idx data last fd ovr
    addVec(1, 0, 0,  0, 0, 0, 8'h00, 0, 0, 0);
    addVec(0, 0, 0,  1, 0, 0, 8'h00, 0, 0, 0);
    addVec(0, 1, FA, 1, 1, 0, 8'h01, 0, 0, 0);
    addVec(0, 1, FA, 1, 1, 1, 8'h05, 0, 0, 0);
    addVec(0, 1, FA, 1, 1, 2, 8'h09, 0, 0, 0);
    addVec(0, 1, FA, 1, 1, 3, 8'hFF, 1, 0, 0);
    addVec(0, 0, 0,  1, 0, 0, 8'h00, 0, 1, 0);
    addVec(0, 0, 0,  1, 0, 0, 8'h00, 0, 0, 0);
    addVec(0, 1, FA, 1, 1, 0, 8'h01, 0, 0, 0);
    addVec(0, 0, 0,  1, 1, 1, 8'h05, 0, 0, 0);
    addVec(0, 0, 0,  1, 1, 2, 8'h09, 0, 0, 0);
    addVec(0, 0, 0,  1, 1, 3, 8'hFF, 1, 0, 0);
    addVec(0, 1, FB, 1, 1, 0, 8'h10, 0, 1, 0);
    addVec(0, 0, 0,  1, 1, 1, 8'h20, 0, 0, 0);
    addVec(0, 0, 0,  1, 1, 2, 8'h30, 0, 0, 0);
    addVec(0, 1, FX, 0, 1, 2, 8'h30, 0, 0, 1);
    addVec(0, 1, FX, 1, 1, 3, 8'h40, 1, 0, 1);
    addVec(0, 0, 0,  1, 0, 0, 8'h00, 0, 1, 1);
    addVec(0, 0, 0,  1, 0, 0, 8'h00, 0, 0, 1);
    addVec(1, 0, 0,  1, 0, 0, 8'h00, 0, 0, 0);

    foreach (vq[i]) begin
      applyStimulus(vq[i].rst, vq[i].done, vq[i].data, vq[i].ready);
      checkOutput("vec_valid", 32'(o_valid), 32'(vq[i].ev));
      checkOutput("vec_index", 32'(o_index), 32'(vq[i].eidx));
      if (vq[i].ev) checkOutput("vec_data", 32'(o_data), 32'(vq[i].edata));
      checkOutput("vec_last", 32'(o_last), 32'(vq[i].elast));
      checkOutput("vec_frame_done", 32'(o_frame_done), 32'(vq[i].efd));
      checkOutput("vec_overrun", 32'(o_overrun), 32'(vq[i].eov));
    end

    // Backpressure: hold ready low for three cycles at index 1.
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, FA, 1);
    applyStimulus(0, 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("bp_hold_index", 32'(o_index), 32'd1);
      checkOutput("bp_hold_data", 32'(o_data), 32'h05);
    end
    applyStimulus(0, 0, 0, 1);
    checkOutput("bp_resume_data", 32'(o_data), 32'h09);
    applyStimulus(0, 0, 0, 1);
    checkOutput("bp_last_data", 32'(o_data), 32'hFF);
    applyStimulus(0, 0, 0, 1);
    checkOutput("bp_frame_done", 32'(o_frame_done), 32'd1);

    // Reset mid-frame at index 2: frame discarded, no completion pulse.
    applyStimulus(0, 1, FA, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("rst_pre_index", 32'(o_index), 32'd2);
    applyStimulus(1, 0, 0, 1);
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_index", 32'(o_index), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_overrun", 32'(o_overrun), 32'd0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("rst_no_frame_done", 32'(o_frame_done), 32'd0);

    // Order check on {03,07,02,09}, then cleared by the next capture.
    applyStimulus(0, 1, FO, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("ord_before", 32'(o_order_err), 32'd0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("ord_set", 32'(o_order_err), 32'(CHECK_EN));
    applyStimulus(0, 0, 0, 1);
    checkOutput("ord_frame_end", 32'(o_order_err), 32'(CHECK_EN));
    applyStimulus(0, 0, 0, 1);
    checkOutput("ord_held_idle", 32'(o_order_err), 32'(CHECK_EN));
    applyStimulus(0, 1, FA, 0);
    checkOutput("ord_cleared", 32'(o_order_err), 32'd0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0,
                    $urandom, $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
